// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with a programmable pattern,
// overlap control, a one-cycle match pulse and a saturating match counter.
module seq_detector_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    input  logic             sequence_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             pattern_load_i,
    input  logic             overlap_i,
    input  logic             clear_count_i,
    output logic             flag_o,
    output logic [CNT_W-1:0] match_count_o
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
    localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] window;
    logic             hit;

    // Window update, match detection and next-state for all registers.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        flag_d = 1'b0;
        cnt_d  = cnt_q;
        window = {hist_q[PAT_W-2:0], sequence_i};
        hit    = in_valid_i && !pattern_load_i &&
                 (fill_q >= FILL_LAST) && (window == pat_q);

        if (pattern_load_i) begin
            // A load flushes history; the bit offered alongside is dropped.
            pat_d  = pattern_i;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid_i) begin
            hist_d = window;
            if (hit && !overlap_i) begin
                fill_d = '0;
            end else if (fill_q < FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        flag_d = hit;

        if (clear_count_i) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            pat_q  <= '0;
            hist_q <= '0;
            fill_q <= '0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flag_o        = flag_q;
    assign match_count_o = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default instance and a
// 2-bit-counter instance share stimulus to exercise counter saturation.
module tb_seq_detector_param;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       seq_b;
    logic [3:0] pattern;
    logic       pattern_load;
    logic       overlap;
    logic       clear_count;
    logic       flag;
    logic [7:0] count;
    logic       flag2;
    logic [1:0] count2;

    int checks;
    int failures;

    seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut (
        .clock_i       (clk),
        .reset_i       (rst_n),
        .in_valid_i    (in_valid),
        .sequence_i    (seq_b),
        .pattern_i     (pattern),
        .pattern_load_i(pattern_load),
        .overlap_i     (overlap),
        .clear_count_i (clear_count),
        .flag_o        (flag),
        .match_count_o (count)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut2 (
        .clock_i       (clk),
        .reset_i       (rst_n),
        .in_valid_i    (in_valid),
        .sequence_i    (seq_b),
        .pattern_i     (pattern),
        .pattern_load_i(pattern_load),
        .overlap_i     (overlap),
        .clear_count_i (clear_count),
        .flag_o        (flag2),
        .match_count_o (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic b,
                       input logic ld, input logic cc);
        in_valid     = v;
        seq_b        = b;
        pattern_load = ld;
        clear_count  = cc;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        seq_b        = 1'b0;
        pattern_load = 1'b0;
        clear_count  = 1'b0;
    endtask

    task automatic load(input logic [3:0] p, input logic cc);
        pattern = p;
        cyc(1'b0, 1'b0, 1'b1, cc);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if (flag !== 1'b0 || count !== 8'd0 || count2 !== 2'd0) begin
            failures++;
            $display("FAIL reset: flag=%b count=%0d count2=%0d want 0 0 0",
                     flag, count, count2);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_match;
        logic [8:0] bits;
        logic [8:0] exp;
        bits = 9'b100101101;
        exp  = 9'b000010000;
        overlap = 1'b1;
        load(4'b0010, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, bits[8-i], 1'b0, 1'b0);
            checks++;
            if (flag !== exp[8-i]) begin
                failures++;
                $display("FAIL t1_flag bit%0d: got %b want %b",
                         i + 1, flag, exp[8-i]);
            end
        end
        checks++;
        if (count !== 8'd1) begin
            failures++;
            $display("FAIL t1_count: got %0d want 1", count);
        end
    endtask

    task automatic test_overlap_modes;
        logic [5:0] bits;
        logic [5:0] exp_ov;
        logic [5:0] exp_no;
        bits   = 6'b101010;
        exp_ov = 6'b000101;
        exp_no = 6'b000100;
        overlap = 1'b1;
        load(4'b1010, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, bits[5-i], 1'b0, 1'b0);
            checks++;
            if (flag !== exp_ov[5-i]) begin
                failures++;
                $display("FAIL t2_ov_flag bit%0d: got %b want %b",
                         i + 1, flag, exp_ov[5-i]);
            end
        end
        checks++;
        if (count !== 8'd2) begin
            failures++;
            $display("FAIL t2_ov_count: got %0d want 2", count);
        end
        overlap = 1'b0;
        load(4'b1010, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, bits[5-i], 1'b0, 1'b0);
            checks++;
            if (flag !== exp_no[5-i]) begin
                failures++;
                $display("FAIL t2_nov_flag bit%0d: got %b want %b",
                         i + 1, flag, exp_no[5-i]);
            end
        end
        checks++;
        if (count !== 8'd1) begin
            failures++;
            $display("FAIL t2_nov_count: got %0d want 1", count);
        end
    endtask

    task automatic test_gap;
        overlap = 1'b1;
        load(4'b0010, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (flag !== 1'b0) begin
                failures++;
                $display("FAIL t3_gap_flag cyc%0d: got %b want 0", i, flag);
            end
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (flag !== 1'b0) begin
            failures++;
            $display("FAIL t3_pre_flag: got %b want 0", flag);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flag !== 1'b1) begin
            failures++;
            $display("FAIL t3_match_flag: got %b want 1", flag);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flag !== 1'b0 || count !== 8'd1) begin
            failures++;
            $display("FAIL t3_after: flag=%b count=%0d want 0 1", flag, count);
        end
    endtask

    task automatic test_saturation;
        logic [7:0] exp;
        logic [1:0] exp_c2;
        exp = 8'b00011111;
        overlap = 1'b1;
        load(4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            exp_c2 = (i < 3) ? 2'd0 : ((i - 2) > 3 ? 2'd3 : 2'(i - 2));
            checks++;
            if (flag2 !== exp[7-i] || count2 !== exp_c2) begin
                failures++;
                $display("FAIL t4_sat bit%0d: flag=%b count2=%0d want %b %0d",
                         i + 1, flag2, count2, exp[7-i], exp_c2);
            end
        end
        checks++;
        if (count !== 8'd5) begin
            failures++;
            $display("FAIL t4_count8: got %0d want 5", count);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (flag2 !== 1'b1 || count2 !== 2'd1 || count !== 8'd1) begin
            failures++;
            $display("FAIL t4_clear_hit: flag=%b count2=%0d count=%0d want 1 1 1",
                     flag2, count2, count);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp;
        exp = 4'b0001;
        overlap = 1'b1;
        load(4'b0010, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 8'd1) begin
            failures++;
            $display("FAIL t5_pre_count: got %0d want 1", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flag !== 1'b0 || count !== 8'd0 || count2 !== 2'd0) begin
            failures++;
            $display("FAIL t5_async: flag=%b count=%0d count2=%0d want 0 0 0",
                     flag, count, count2);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (flag !== exp[3-i]) begin
                failures++;
                $display("FAIL t5_zero_pat bit%0d: got %b want %b",
                         i + 1, flag, exp[3-i]);
            end
        end
    endtask

    task automatic test_load_discard;
        logic [3:0] bits;
        logic [3:0] exp;
        bits = 4'b0110;
        exp  = 4'b0001;
        overlap = 1'b1;
        load(4'b0110, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, bits[3-i], 1'b0, 1'b0);
            checks++;
            if (flag !== 1'b0) begin
                failures++;
                $display("FAIL t6_pre bit%0d: got %b want 0", i + 1, flag);
            end
        end
        pattern = 4'b0110;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (flag !== 1'b0) begin
            failures++;
            $display("FAIL t6_load_bit: got %b want 0", flag);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, bits[3-i], 1'b0, 1'b0);
            checks++;
            if (flag !== exp[3-i]) begin
                failures++;
                $display("FAIL t6_post bit%0d: got %b want %b",
                         i + 1, flag, exp[3-i]);
            end
        end
        checks++;
        if (count !== 8'd1) begin
            failures++;
            $display("FAIL t6_count: got %0d want 1", count);
        end
    endtask

    task automatic test_clear_only;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count !== 8'd0 || flag !== 1'b0) begin
            failures++;
            $display("FAIL clear_only: count=%0d flag=%b want 0 0", count, flag);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flag !== 1'b1 || count !== 8'd1) begin
            failures++;
            $display("FAIL clear_keeps_window: flag=%b count=%0d want 1 1",
                     flag, count);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        seq_b        = 1'b0;
        pattern      = 4'b0000;
        pattern_load = 1'b0;
        overlap      = 1'b1;
        clear_count  = 1'b0;
        #1;
        test_reset;
        test_single_match;
        test_overlap_modes;
        test_gap;
        test_saturation;
        test_reset_mid;
        test_load_discard;
        test_clear_only;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
